// File: rtl/uart_tx_io_if.sv
// uart_tx_io_if: CPU IO-bus connection of the UART transmitter peripheral.
// master = CPU side (strobes, address, store data); slave = peripheral (load data).
interface uart_tx_io_if;
    logic        io_sel;
    logic        ioWrite;
    logic        ioRead;
    logic        io_addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output io_sel,
        output ioWrite,
        output ioRead,
        output io_addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  io_sel,
        input  ioWrite,
        input  ioRead,
        input  io_addr,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/uart_tx_io.sv
// uart_tx_io: memory-mapped UART transmitter. Bytes stored to TXDATA are
// buffered in a FIFO and sent 8N1, LSB first, on tx; STATUS is polled by load.
// Ports: clock, reset (sync, active high), bus (uart_tx_io_if.slave:
// io_sel/ioWrite/ioRead/io_addr/wdata in, rdata out), tx (registered, idle 1).
// Option: define UART_TX_PARITY_EN to insert an even-parity bit before stop.
module uart_tx_io #(
    parameter int CLK_HZ     = 23000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    uart_tx_io_if.slave bus,
    output logic        tx
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int BW  = $clog2(DIV);
    localparam int AW  = $clog2(FIFO_DEPTH);

    localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
    localparam logic [3:0]    DEPTH_C   = 4'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [3:0]    count_q;
    logic          ovf_q;

    logic [BW-1:0] baud_q;
    logic [BW-1:0] baud_d;
    logic [2:0]    bit_q;
    logic [2:0]    bit_d;
    logic [7:0]    shift_q;
    logic [7:0]    shift_d;
    logic          tx_d;

    logic          empty;
    logic          full;
    logic          busy;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          stat_rd;
    logic          baud_end;
    logic          bit_last;
    logic [7:0]    head;
    logic          unused_wdata;

    assign empty    = count_q == 4'd0;
    assign full     = count_q == DEPTH_C;
    assign busy     = state_q != IDLE;
    assign push_req = bus.io_sel & bus.ioWrite & ~bus.io_addr;
    // Full is judged on the pre-edge count, so a same-cycle pop cannot rescue it.
    assign push     = push_req & ~full;
    assign stat_rd  = bus.io_sel & bus.ioRead & bus.io_addr;
    assign baud_end = baud_q == BAUD_LAST;
    assign bit_last = bit_q == 3'd7;
    assign head     = mem[rd_ptr_q];

    assign unused_wdata = ^bus.wdata[31:8];

    assign bus.rdata = stat_rd
        ? {24'd0, count_q, ovf_q, empty, full, busy}
        : 32'd0;

    // FIFO storage: no reset needed, occupancy is tracked by count_q.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.wdata[7:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 4'd0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 4'd1;
                2'b01:   count_q <= count_q - 4'd1;
                default: count_q <= count_q;
            endcase
            // An overflowing push beats a same-cycle clear.
            if (push_req & full) begin
                ovf_q <= 1'b1;
            end else if (stat_rd) begin
                ovf_q <= 1'b0;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    // Even parity captured at load time, before the shifter is consumed.
    logic par_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            par_q <= 1'b0;
        end else if (pop) begin
            par_q <= ^head;
        end
    end
`endif

    // FSM: state and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            tx      <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx      <= tx_d;
        end
    end

    // FSM: next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = START;
                end
            end
            START: begin
                if (baud_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_end && bit_last) begin
`ifdef UART_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_end) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                // Back-to-back frames: a queued byte skips IDLE entirely.
                if (baud_end) begin
                    state_d = empty ? IDLE : START;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs, FIFO pop and bit timing.
    always_comb begin
        pop     = 1'b0;
        tx_d    = tx;
        baud_d  = baud_end ? '0 : baud_q + BW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    tx_d    = 1'b0;
                    shift_d = head;
                end
            end
            START: begin
                if (baud_end) begin
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = 3'd0;
                end
            end
            DATA: begin
                if (baud_end) begin
                    if (bit_last) begin
`ifdef UART_TX_PARITY_EN
                        tx_d = par_q;
`else
                        tx_d = 1'b1;
`endif
                        bit_d = 3'd0;
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_end) begin
                    tx_d = 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_end && !empty) begin
                    pop     = 1'b1;
                    tx_d    = 1'b0;
                    shift_d = head;
                end
            end
            default: begin
                baud_d = '0;
                tx_d   = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_tx_io.sv
// tb_uart_tx_io: directed and randomized bench for uart_tx_io against a
// frame-level model (byte queue + frame timer); checks tx and rdata every cycle.
module tb_uart_tx_io;
    localparam int CLK_HZ = 16;
    localparam int BAUD   = 1;
    localparam int DEPTH  = 8;
    localparam int DIV    = CLK_HZ / BAUD;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS  = 11;
`else
    localparam int NBITS  = 10;
`endif
    localparam int FRAME  = NBITS * DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    uart_tx_io_if bus();

    uart_tx_io #(
        .CLK_HZ(CLK_HZ),
        .BAUD(BAUD),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus(bus),
        .tx(tx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 0x%08h, expected 0x%08h",
                     name, cyc, act, exp);
        end
    endtask

    // Frame-level model: queued bytes, and a frame timer for the byte on the line.
    logic [7:0] mq[$];
    bit         m_ok = 1'b0;
    bit         m_act = 1'b0;
    int         m_t = 0;
    logic [7:0] m_byte = 8'd0;
    bit         m_ovf = 1'b0;

    always @(posedge clk) begin : model
        bit wr_hit;
        bit rd_hit;
        bit was_full;
        if (rst) begin
            mq.delete();
            m_act = 1'b0;
            m_t   = 0;
            m_ovf = 1'b0;
            m_ok  = 1'b1;
        end else if (m_ok) begin
            wr_hit   = bus.io_sel && bus.ioWrite && !bus.io_addr;
            rd_hit   = bus.io_sel && bus.ioRead && bus.io_addr;
            was_full = mq.size() == DEPTH;
            if (m_act) begin
                m_t++;
                if (m_t == FRAME) m_act = 1'b0;
            end
            if (!m_act && mq.size() != 0) begin
                m_byte = mq.pop_front();
                m_act  = 1'b1;
                m_t    = 0;
            end
            if (wr_hit && !was_full) mq.push_back(bus.wdata[7:0]);
            if (wr_hit && was_full) m_ovf = 1'b1;
            else if (rd_hit) m_ovf = 1'b0;
        end
    end

    function automatic logic exp_tx();
        int k;
        if (!m_act) return 1'b1;
        k = m_t / DIV;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_byte[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^m_byte;
`endif
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_status();
        return {24'd0, 4'(mq.size()), m_ovf, mq.size() == 0,
                mq.size() == DEPTH, m_act};
    endfunction

    function automatic logic [31:0] exp_rdata();
        if (bus.io_sel && bus.ioRead && bus.io_addr) return exp_status();
        return 32'd0;
    endfunction

    always @(posedge clk) begin
        #1;
        if (m_ok) begin
            chk("tx_model", 32'(tx), 32'(exp_tx()));
            chk("rdata_model", bus.rdata, exp_rdata());
        end
    end

    task automatic idle_bus();
        bus.io_sel  = 1'b0;
        bus.ioWrite = 1'b0;
        bus.ioRead  = 1'b0;
        bus.io_addr = 1'b0;
        bus.wdata   = 32'd0;
    endtask

    task automatic goto_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] b, output int c0);
        bus.io_sel  = 1'b1;
        bus.ioWrite = 1'b1;
        bus.ioRead  = 1'b0;
        bus.io_addr = 1'b0;
        bus.wdata   = {24'($urandom()), b};
        c0 = cyc + 1;
        @(negedge clk);
        idle_bus();
    endtask

    task automatic rd_status(output logic [31:0] v);
        bus.io_sel  = 1'b1;
        bus.ioWrite = 1'b0;
        bus.ioRead  = 1'b1;
        bus.io_addr = 1'b1;
        #1 v = bus.rdata;
        @(negedge clk);
        idle_bus();
    endtask

    // s = edge count at which the start bit first appears; pat bit j = frame bit j.
    task automatic chk_frame(input string name, input int s,
                             input logic [9:0] pat);
        int k;
        for (int j = 0; j < 10; j++) begin
            k = (j == 9) ? NBITS - 1 : j;
            goto_cyc(s + k * DIV + DIV / 2);
            chk(name, 32'(tx), 32'(pat[j]));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        int c0;
        int c1;
        int s;
        int wprob;

        idle_bus();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_tx", 32'(tx), 32'd1);
        rd_status(v);
        chk("reset_status", v, 32'h4);

        // Single byte 0x55.
        wr(8'h55, c0);
        s = c0 + 1;
        chk("t55_pre", 32'(tx), 32'd1);
        goto_cyc(s);
        chk("t55_start", 32'(tx), 32'd0);
        chk_frame("t55_bits", s, 10'b1010101010);
        goto_cyc(s + FRAME - 2);
        rd_status(v);
        chk("t55_busy", v, 32'h5);
        goto_cyc(s + FRAME);
        rd_status(v);
        chk("t55_done", v, 32'h4);

        // Ten writes on consecutive cycles: one shifted, eight queued, one dropped.
        for (int i = 0; i < 10; i++) begin
            bus.io_sel  = 1'b1;
            bus.ioWrite = 1'b1;
            bus.io_addr = 1'b0;
            bus.wdata   = $urandom();
            if (i == 0) c0 = cyc + 1;
            @(negedge clk);
        end
        idle_bus();
        rd_status(v);
        chk("burst_ovf", v, 32'h8B);
        rd_status(v);
        chk("burst_ovf_clr", v, 32'h83);
        s = c0 + 1;
        goto_cyc(s + FRAME - 1);
        chk("burst_stop1", 32'(tx), 32'd1);
        goto_cyc(s + FRAME);
        chk("burst_start2", 32'(tx), 32'd0);
        goto_cyc(s + 9 * FRAME - 1);
        rd_status(v);
        chk("burst_last", v, 32'h5);
        rd_status(v);
        chk("burst_end", v, 32'h4);

        // Two bytes back to back.
        wr(8'hA3, c0);
        wr(8'h0F, c1);
        s = c0 + 1;
        chk_frame("tA3_bits", s, 10'b1101000110);
        goto_cyc(s + FRAME - 1);
        chk("tA3_stop", 32'(tx), 32'd1);
        goto_cyc(s + FRAME);
        chk("t0F_start", 32'(tx), 32'd0);
        chk_frame("t0F_bits", s + FRAME, 10'b1000011110);
        goto_cyc(s + 2 * FRAME + 1);
        rd_status(v);
        chk("t0F_done", v, 32'h4);

        // Reset in the middle of a frame with two bytes queued.
        wr(8'h00, c0);
        wr(8'h11, c1);
        wr(8'h22, c1);
        s = c0 + 1;
        goto_cyc(s + 40);
        chk("rst_mid_low", 32'(tx), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_tx", 32'(tx), 32'd1);
        rd_status(v);
        chk("rst_mid_status", v, 32'h4);
        goto_cyc(cyc + 2 * FRAME);
        chk("rst_mid_quiet", 32'(tx), 32'd1);
        rd_status(v);
        chk("rst_mid_status2", v, 32'h4);

`ifdef UART_TX_PARITY_EN
        wr(8'h07, c0);
        s = c0 + 1;
        goto_cyc(s + 9 * DIV + DIV / 2);
        chk("par07_bit", 32'(tx), 32'd1);
        goto_cyc(s + 10 * DIV);
        chk("par07_stop", 32'(tx), 32'd1);
        goto_cyc(s + FRAME - 1);
        rd_status(v);
        chk("par07_busy", v, 32'h5);
        rd_status(v);
        chk("par07_done", v, 32'h4);
        wr(8'h03, c0);
        s = c0 + 1;
        goto_cyc(s + 10 * DIV - 1);
        chk("par03_bit", 32'(tx), 32'd0);
        goto_cyc(s + 10 * DIV);
        chk("par03_stop", 32'(tx), 32'd1);
        goto_cyc(s + FRAME + 1);
`endif

        // Randomized traffic: alternating fill and drain phases, rare resets.
        for (int n = 0; n < 4000; n++) begin
            wprob = ((n / 500) % 2 == 1) ? 20 : 1;
            rst = $urandom_range(0, 499) == 0;
            bus.io_sel  = $urandom_range(0, 9) != 0;
            bus.ioWrite = $urandom_range(0, 99) < wprob;
            bus.ioRead  = $urandom_range(0, 3) == 0;
            if (bus.ioWrite)
                bus.io_addr = $urandom_range(0, 7) == 0;
            else
                bus.io_addr = $urandom_range(0, 3) != 0;
            bus.wdata = $urandom();
            @(negedge clk);
        end
        rst = 1'b0;
        idle_bus();
        goto_cyc(cyc + (DEPTH + 1) * FRAME + 4);
        rd_status(v);
        chk("rand_drain", v & 32'hF7, 32'h4);
        rd_status(v);
        chk("rand_final", v, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
